// File: rtl/lms_ctr_nios2_oci_pkg.sv
// Shared types and constants for the OCI RAM arbiter: FSM states, grant ids, bus widths.
package lms_ctr_nios2_oci_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic GNT_DBG = 1'b0;
  localparam logic GNT_TRC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/lms_ctr_nios2_oci_rr2.sv
// Two-way round-robin winner select with a last-grant pointer.
// The lock input forces dbg to win every tie.
module lms_ctr_nios2_oci_rr2
  import lms_ctr_nios2_oci_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_dbg,
  input  logic req_trc,
  input  logic lock,
  input  logic advance,
  output logic win
);

  logic last_gnt;

  always_comb begin
    win = GNT_DBG;
    if (req_dbg && req_trc)
      win = (lock || (last_gnt == GNT_TRC)) ? GNT_DBG : GNT_TRC;
    else if (req_trc)
      win = GNT_TRC;
  end

  // Pointer starts at trc so dbg takes the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset)
      last_gnt <= GNT_TRC;
    else if (advance)
      last_gnt <= win;
  end

endmodule

// File: rtl/lms_ctr_nios2_oci_mem_arb.sv
// Arbitrates the debug-slave and trace-readout ports onto the single OCI RAM port.
// Optional OCI_ARB_DBG_LOCK_EN adds dbg_lock, which makes dbg win every tie.
module lms_ctr_nios2_oci_mem_arb
  import lms_ctr_nios2_oci_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              trc_req,
  input  logic [ADDR_W-1:0] trc_addr,
  output logic              trc_ack,
  output logic [DATA_W-1:0] trc_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_id
`ifdef OCI_ARB_DBG_LOCK_EN
  ,
  input  logic              dbg_lock
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  arb_state_t state;
  logic [2:0] wait_cnt;
  logic       lock;
  logic       win;
  logic       sample;

`ifdef OCI_ARB_DBG_LOCK_EN
  assign lock = dbg_lock;
`else
  assign lock = 1'b0;
`endif

  assign sample = (state == IDLE) && (dbg_req || trc_req);

  lms_ctr_nios2_oci_rr2 u_rr2 (
    .clk     (clk),
    .reset   (reset),
    .req_dbg (dbg_req),
    .req_trc (trc_req),
    .lock    (lock),
    .advance (sample),
    .win     (win)
  );

  // ram_we doubles as the latched write flag while in ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      dbg_ack   <= 1'b0;
      trc_ack   <= 1'b0;
      dbg_rdata <= '0;
      trc_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      grant_id  <= GNT_DBG;
    end else begin
      case (state)
        IDLE: begin
          if (sample) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            grant_id <= win;
            ram_en   <= 1'b1;
            if (win == GNT_DBG) begin
              ram_we    <= dbg_we;
              ram_addr  <= dbg_addr;
              ram_wdata <= dbg_wdata;
            end else begin
              ram_we    <= 1'b0;
              ram_addr  <= trc_addr;
              ram_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          wait_cnt <= '0;
          if (ram_we) begin
            state   <= DONE;
            dbg_ack <= (grant_id == GNT_DBG);
            trc_ack <= (grant_id == GNT_TRC);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == LAT_LAST) begin
            state <= DONE;
            if (grant_id == GNT_DBG) begin
              dbg_rdata <= ram_rdata;
              dbg_ack   <= 1'b1;
            end else begin
              trc_rdata <= ram_rdata;
              trc_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          dbg_ack <= 1'b0;
          trc_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
